// File: rtl/lvds_multi_lane_dpa_ctrl_if.sv
// Bus between the DPA sequencer and the per-lane comparator/deserialiser logic.
// The controller uses the slave modport; whatever drives start and match uses master.
interface lvds_multi_lane_dpa_ctrl_if #(
  parameter int NUM_LANES = 4,
  parameter int TAP_W     = 8
);
  logic                       I_dpa_start;
  logic [NUM_LANES-1:0]       I_lane_match;
  logic [NUM_LANES*TAP_W-1:0] O_idelay_num;
  logic [NUM_LANES*TAP_W-1:0] O_eye_taps;
  logic [NUM_LANES-1:0]       O_lane_dpa_done;
  logic [NUM_LANES-1:0]       O_lane_fail;
  logic                       O_all_done;
  logic                       O_busy;

  modport master (
    output I_dpa_start, I_lane_match,
    input  O_idelay_num, O_eye_taps, O_lane_dpa_done, O_lane_fail, O_all_done, O_busy
  );

  modport slave (
    input  I_dpa_start, I_lane_match,
    output O_idelay_num, O_eye_taps, O_lane_dpa_done, O_lane_fail, O_all_done, O_busy
  );
endinterface

// File: rtl/lvds_multi_lane_dpa_ctrl.sv
// Multi-lane DPA sequencer: sweeps each lane's idelay tap, centres it in the widest
// passing eye, then watches calibrated lanes and re-scans any that lose match.
module lvds_multi_lane_dpa_ctrl #(
  parameter int NUM_LANES  = 4,
  parameter int TAP_W      = 8,
  parameter int MAX_TAP    = 255,
  parameter int SETTLE_CYC = 16,
  parameter int DWELL_CYC  = 64,
  parameter int MIN_EYE    = 8,
  parameter int AUTO_RECAL = 1,
  parameter int ERR_LIMIT  = 32
) (
  input logic                       I_clk,
  input logic                       I_rst_n,
  lvds_multi_lane_dpa_ctrl_if.slave bus
);
  localparam int LANE_W  = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int CNT_MAX = (SETTLE_CYC > DWELL_CYC) ? SETTLE_CYC : DWELL_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int ERR_W   = $clog2(ERR_LIMIT + 1);
  localparam int RUN_W   = TAP_W + 1;

  typedef enum logic [2:0] {IDLE, SET_TAP, DWELL, EVAL, CENTER, NEXT_LANE, MONITOR} state_t;

  state_t               state_reg;
  logic [LANE_W-1:0]    lane_reg;
  logic [TAP_W-1:0]     tap_reg;
  logic [CNT_W-1:0]     cnt_reg;
  logic                 pass_reg;
  logic                 rescan_reg;
  logic [RUN_W-1:0]     run_len_reg, best_len_reg;
  logic [TAP_W-1:0]     run_start_reg, best_start_reg;
  logic [TAP_W-1:0]     idelay_reg [NUM_LANES];
  logic [TAP_W-1:0]     eye_reg    [NUM_LANES];
  logic [NUM_LANES-1:0] done_reg, fail_reg, pending_reg;
  logic                 all_done_reg, busy_reg;

  logic [NUM_LANES-1:0] lane_sel, err_trip, pend_onehot, done_base, pend_base;
  logic [LANE_W-1:0]    pend_idx;
  logic                 cur_match;
  logic [RUN_W-1:0]     run_len_next;
  logic [TAP_W-1:0]     run_start_next, half_len, center_tap, eye_sat;
  logic                 run_close, eye_ok;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      logic [ERR_W-1:0] err_reg;

      // Consecutive-mismatch counter; only meaningful while the lane is in service.
      always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
          err_reg <= '0;
        end else if (!done_reg[gi] || bus.I_lane_match[gi]) begin
          err_reg <= '0;
        end else if (err_reg != ERR_W'(ERR_LIMIT)) begin
          err_reg <= err_reg + ERR_W'(1);
        end
      end

      assign err_trip[gi] = (AUTO_RECAL != 0) && done_reg[gi] && !bus.I_lane_match[gi]
                            && (err_reg == ERR_W'(ERR_LIMIT - 1));
      assign lane_sel[gi] = (lane_reg == LANE_W'(gi));
      assign bus.O_idelay_num[gi*TAP_W +: TAP_W] = idelay_reg[gi];
      assign bus.O_eye_taps[gi*TAP_W +: TAP_W]   = eye_reg[gi];
    end
  endgenerate

  assign cur_match   = |(bus.I_lane_match & lane_sel);
  assign pend_onehot = pending_reg & (~pending_reg + NUM_LANES'(1));
  assign done_base   = done_reg & ~err_trip;
  assign pend_base   = pending_reg | err_trip;

  always_comb begin
    pend_idx = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (pending_reg[i]) pend_idx = LANE_W'(i);
    end
  end

  // A run closes on a failing tap or on a pass at the last tap of the sweep.
  assign run_len_next   = pass_reg ? run_len_reg + RUN_W'(1) : run_len_reg;
  assign run_start_next = (pass_reg && run_len_reg == '0) ? tap_reg : run_start_reg;
  assign run_close      = !pass_reg || (tap_reg == TAP_W'(MAX_TAP));

  assign half_len   = TAP_W'((best_len_reg - RUN_W'(1)) >> 1);
  assign center_tap = best_start_reg + half_len;
  assign eye_sat    = best_len_reg[TAP_W] ? '1 : best_len_reg[TAP_W-1:0];
  assign eye_ok     = best_len_reg >= RUN_W'(MIN_EYE);

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_reg      <= IDLE;
      lane_reg       <= '0;
      tap_reg        <= '0;
      cnt_reg        <= '0;
      pass_reg       <= 1'b0;
      rescan_reg     <= 1'b0;
      run_len_reg    <= '0;
      best_len_reg   <= '0;
      run_start_reg  <= '0;
      best_start_reg <= '0;
      done_reg       <= '0;
      fail_reg       <= '0;
      pending_reg    <= '0;
      all_done_reg   <= 1'b0;
      busy_reg       <= 1'b0;
      for (int i = 0; i < NUM_LANES; i++) begin
        idelay_reg[i] <= '0;
        eye_reg[i]    <= '0;
      end
    end else begin
      all_done_reg <= (&done_reg) & ~(|fail_reg);
      done_reg     <= done_base;
      pending_reg  <= pend_base;

      if (bus.I_dpa_start) begin
        // Abort from any state; idelay values are left alone until each lane is rescanned.
        done_reg       <= '0;
        fail_reg       <= '0;
        pending_reg    <= '0;
        lane_reg       <= '0;
        tap_reg        <= '0;
        cnt_reg        <= '0;
        run_len_reg    <= '0;
        best_len_reg   <= '0;
        run_start_reg  <= '0;
        best_start_reg <= '0;
        rescan_reg     <= 1'b0;
        busy_reg       <= 1'b1;
        state_reg      <= SET_TAP;
        for (int i = 0; i < NUM_LANES; i++) eye_reg[i] <= '0;
      end else begin
        case (state_reg)
          IDLE: ;
          SET_TAP: begin
            for (int i = 0; i < NUM_LANES; i++) begin
              if (lane_sel[i]) idelay_reg[i] <= tap_reg;
            end
            if (cnt_reg == CNT_W'(SETTLE_CYC - 1)) begin
              cnt_reg   <= '0;
              pass_reg  <= 1'b1;
              state_reg <= DWELL;
            end else begin
              cnt_reg <= cnt_reg + CNT_W'(1);
            end
          end
          DWELL: begin
            pass_reg <= pass_reg & cur_match;
            if (cnt_reg == CNT_W'(DWELL_CYC - 1)) begin
              cnt_reg   <= '0;
              state_reg <= EVAL;
            end else begin
              cnt_reg <= cnt_reg + CNT_W'(1);
            end
          end
          EVAL: begin
            if (run_close) begin
              if (run_len_next > best_len_reg) begin
                best_len_reg   <= run_len_next;
                best_start_reg <= run_start_next;
              end
              run_len_reg <= '0;
            end else begin
              run_len_reg   <= run_len_next;
              run_start_reg <= run_start_next;
            end
            if (tap_reg < TAP_W'(MAX_TAP)) begin
              tap_reg   <= tap_reg + TAP_W'(1);
              state_reg <= SET_TAP;
            end else begin
              state_reg <= CENTER;
            end
          end
          CENTER: begin
            for (int i = 0; i < NUM_LANES; i++) begin
              if (lane_sel[i]) begin
                idelay_reg[i] <= eye_ok ? center_tap : '0;
                eye_reg[i]    <= eye_sat;
              end
            end
            done_reg  <= eye_ok ? (done_base | lane_sel) : (done_base & ~lane_sel);
            fail_reg  <= eye_ok ? (fail_reg & ~lane_sel) : (fail_reg | lane_sel);
            state_reg <= NEXT_LANE;
          end
          NEXT_LANE: begin
            if (!rescan_reg && lane_reg != LANE_W'(NUM_LANES - 1)) begin
              lane_reg       <= lane_reg + LANE_W'(1);
              tap_reg        <= '0;
              run_len_reg    <= '0;
              best_len_reg   <= '0;
              run_start_reg  <= '0;
              best_start_reg <= '0;
              state_reg      <= SET_TAP;
            end else begin
              rescan_reg <= 1'b0;
              busy_reg   <= 1'b0;
              state_reg  <= MONITOR;
            end
          end
          MONITOR: begin
            if (|pending_reg) begin
              lane_reg       <= pend_idx;
              tap_reg        <= '0;
              cnt_reg        <= '0;
              run_len_reg    <= '0;
              best_len_reg   <= '0;
              run_start_reg  <= '0;
              best_start_reg <= '0;
              rescan_reg     <= 1'b1;
              busy_reg       <= 1'b1;
              pending_reg    <= pend_base & ~pend_onehot;
              state_reg      <= SET_TAP;
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign bus.O_lane_dpa_done = done_reg;
  assign bus.O_lane_fail     = fail_reg;
  assign bus.O_all_done      = all_done_reg;
  assign bus.O_busy          = busy_reg;
endmodule

// File: tb/tb_lvds_multi_lane_dpa_ctrl.sv
// Bench for the DPA sequencer: a two-lane auto-recal instance and a one-lane monitor-only
// instance, each fed by a channel model whose match depends on the tap currently applied.
module tb_lvds_multi_lane_dpa_ctrl;
  localparam int TAP_W     = 8;
  localparam int MAX_TAP   = 63;
  localparam int SETTLE    = 2;
  localparam int DWELL     = 4;
  localparam int MIN_EYE   = 8;
  localparam int ERR_LIMIT = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lvds_multi_lane_dpa_ctrl_if #(.NUM_LANES(2), .TAP_W(TAP_W)) ifa ();
  lvds_multi_lane_dpa_ctrl_if #(.NUM_LANES(1), .TAP_W(TAP_W)) ifb ();

  lvds_multi_lane_dpa_ctrl #(
    .NUM_LANES(2), .TAP_W(TAP_W), .MAX_TAP(MAX_TAP), .SETTLE_CYC(SETTLE), .DWELL_CYC(DWELL),
    .MIN_EYE(MIN_EYE), .AUTO_RECAL(1), .ERR_LIMIT(ERR_LIMIT)
  ) dut_a (.I_clk(clk), .I_rst_n(rst_n), .bus(ifa));

  lvds_multi_lane_dpa_ctrl #(
    .NUM_LANES(1), .TAP_W(TAP_W), .MAX_TAP(MAX_TAP), .SETTLE_CYC(SETTLE), .DWELL_CYC(DWELL),
    .MIN_EYE(MIN_EYE), .AUTO_RECAL(0), .ERR_LIMIT(ERR_LIMIT)
  ) dut_b (.I_clk(clk), .I_rst_n(rst_n), .bus(ifb));

  int checks = 0;
  int errors = 0;

  logic [63:0] mask_a [2];
  logic [63:0] mask_b;
  logic [1:0]  drop_a;
  logic        drop_b;

  // Channel: a lane matches when its applied tap lies inside that lane's eye mask.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      int idx;
      idx = int'(ifa.O_idelay_num[i*TAP_W +: TAP_W]);
      ifa.I_lane_match[i] = (idx < 64) ? (mask_a[i][idx] & ~drop_a[i]) : 1'b0;
    end
  end

  always_comb begin
    int idx;
    idx = int'(ifb.O_idelay_num[TAP_W-1:0]);
    ifb.I_lane_match[0] = (idx < 64) ? (mask_b[idx] & ~drop_b) : 1'b0;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] win(input int s, input int e);
    logic [63:0] m;
    m = '0;
    for (int t = s; t <= e && t < 64; t++) m[t] = 1'b1;
    return m;
  endfunction

  // Reference: longest contiguous run of passing taps (earliest on ties), centred.
  function automatic void model(input logic [63:0] m, output int idl, output int eye,
                                output int dn, output int fl);
    int best_len, best_start;
    best_len = 0;
    best_start = 0;
    for (int s = 0; s < 64; s++) begin
      if (m[s] && (s == 0 || !m[s-1])) begin
        int len;
        len = 0;
        while (s + len < 64 && m[s+len]) len++;
        if (len > best_len) begin
          best_len = len;
          best_start = s;
        end
      end
    end
    eye = (best_len > 255) ? 255 : best_len;
    if (best_len >= MIN_EYE) begin
      idl = best_start + (best_len - 1) / 2;
      dn = 1;
      fl = 0;
    end else begin
      idl = 0;
      dn = 0;
      fl = 1;
    end
  endfunction

  function automatic logic [63:0] rand_mask();
    logic [63:0] m;
    int s, l;
    m = '0;
    case ($urandom_range(0, 3))
      0: m = '0;
      1: begin
        s = $urandom_range(0, 63);
        l = $urandom_range(1, 30);
        m = win(s, s + l - 1);
      end
      2: begin
        s = $urandom_range(0, 25);
        l = $urandom_range(1, 20);
        m = win(s, s + l - 1);
        s = $urandom_range(30, 63);
        l = $urandom_range(1, 20);
        m |= win(s, s + l - 1);
      end
      default: m = {$urandom, $urandom} | {$urandom, $urandom};
    endcase
    return m;
  endfunction

  task automatic pulse_a();
    @(negedge clk) ifa.I_dpa_start = 1'b1;
    @(negedge clk) ifa.I_dpa_start = 1'b0;
  endtask

  task automatic pulse_b();
    @(negedge clk) ifb.I_dpa_start = 1'b1;
    @(negedge clk) ifb.I_dpa_start = 1'b0;
  endtask

  task automatic wait_idle_a();
    int n;
    n = 0;
    while (ifa.O_busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("a_busy_timeout", ifa.O_busy, 0);
  endtask

  task automatic run_a();
    pulse_a();
    wait_idle_a();
    @(negedge clk);
  endtask

  task automatic run_b(input logic [63:0] m);
    int n;
    mask_b = m;
    pulse_b();
    n = 0;
    while (ifb.O_busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("b_busy_timeout", ifb.O_busy, 0);
    @(negedge clk);
  endtask

  task automatic check_lane_a(input int i, input string tag);
    int idl, eye, dn, fl;
    model(mask_a[i], idl, eye, dn, fl);
    check($sformatf("%s_idelay%0d", tag, i), ifa.O_idelay_num[i*TAP_W +: TAP_W], idl);
    check($sformatf("%s_eye%0d", tag, i), ifa.O_eye_taps[i*TAP_W +: TAP_W], eye);
    check($sformatf("%s_done%0d", tag, i), ifa.O_lane_dpa_done[i], dn);
    check($sformatf("%s_fail%0d", tag, i), ifa.O_lane_fail[i], fl);
  endtask

  task automatic check_all_done_a(input string tag);
    int idl, eye, d0, f0, d1, f1;
    model(mask_a[0], idl, eye, d0, f0);
    model(mask_a[1], idl, eye, d1, f1);
    check(tag, ifa.O_all_done, (d0 & d1 & ~f0 & ~f1) & 1);
  endtask

  initial begin
    int n;
    int idl0_saved;
    int s, l;

    ifa.I_dpa_start = 1'b0;
    ifb.I_dpa_start = 1'b0;
    drop_a = '0;
    drop_b = 1'b0;
    mask_a[0] = '0;
    mask_a[1] = '0;
    mask_b = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_a_busy", ifa.O_busy, 0);
    check("rst_a_all_done", ifa.O_all_done, 0);
    check("rst_a_done", ifa.O_lane_dpa_done, 0);
    check("rst_a_fail", ifa.O_lane_fail, 0);
    check("rst_a_idelay", ifa.O_idelay_num, 0);
    check("rst_a_eye", ifa.O_eye_taps, 0);
    check("rst_b_busy", ifb.O_busy, 0);
    check("rst_b_done", ifb.O_lane_dpa_done, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single window 20..35 on the one-lane instance, with scan duration
    mask_b = win(20, 35);
    pulse_b();
    n = 0;
    while (ifb.O_busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("b_scan_cycles", n, 64 * 7 + 2);
    check("b_win_idelay", ifb.O_idelay_num, 27);
    check("b_win_eye", ifb.O_eye_taps, 16);
    check("b_win_done", ifb.O_lane_dpa_done, 1);
    check("b_win_fail", ifb.O_lane_fail, 0);
    check("b_win_all_done", ifb.O_all_done, 1);

    // Equal-width windows keep the earlier one; a wider later window wins
    run_b(win(5, 14) | win(40, 49));
    check("b_tie_idelay", ifb.O_idelay_num, 9);
    check("b_tie_eye", ifb.O_eye_taps, 10);
    run_b(win(5, 14) | win(40, 50));
    check("b_wide_idelay", ifb.O_idelay_num, 45);
    check("b_wide_eye", ifb.O_eye_taps, 11);

    // Monitor-only instance ignores a long mismatch
    drop_b = 1'b1;
    repeat (100) @(negedge clk);
    check("b_norecal_done", ifb.O_lane_dpa_done, 1);
    check("b_norecal_busy", ifb.O_busy, 0);
    check("b_norecal_all_done", ifb.O_all_done, 1);
    drop_b = 1'b0;

    // Full-range eye on lane 0, dead lane 1
    mask_a[0] = win(0, 63);
    mask_a[1] = '0;
    run_a();
    check("a_full_idelay0", ifa.O_idelay_num[TAP_W-1:0], 31);
    check("a_full_eye0", ifa.O_eye_taps[TAP_W-1:0], 64);
    check("a_full_done0", ifa.O_lane_dpa_done[0], 1);
    check("a_full_fail1", ifa.O_lane_fail[1], 1);
    check("a_full_idelay1", ifa.O_idelay_num[TAP_W +: TAP_W], 0);
    check("a_full_eye1", ifa.O_eye_taps[TAP_W +: TAP_W], 0);
    check("a_full_all_done", ifa.O_all_done, 0);

    // Randomised eye patterns against the reference
    for (int r = 0; r < 4; r++) begin
      mask_a[0] = rand_mask();
      mask_a[1] = rand_mask();
      run_a();
      check_lane_a(0, $sformatf("rnd%0d", r));
      check_lane_a(1, $sformatf("rnd%0d", r));
      check_all_done_a($sformatf("rnd%0d_all_done", r));
    end

    // Auto re-scan: two good lanes, then lane 1 loses match
    for (int i = 0; i < 2; i++) begin
      s = $urandom_range(0, 50);
      l = $urandom_range(MIN_EYE, 64 - s);
      mask_a[i] = win(s, s + l - 1);
    end
    run_a();
    check_lane_a(0, "mon");
    check_lane_a(1, "mon");
    check("mon_all_done", ifa.O_all_done, 1);
    idl0_saved = int'(ifa.O_idelay_num[TAP_W-1:0]);

    drop_a[1] = 1'b1;
    repeat (ERR_LIMIT - 1) @(negedge clk);
    drop_a[1] = 1'b0;
    check("mon_short_done1", ifa.O_lane_dpa_done[1], 1);
    check("mon_short_busy", ifa.O_busy, 0);
    repeat (3) @(negedge clk);
    check("mon_short_busy_later", ifa.O_busy, 0);

    drop_a[1] = 1'b1;
    repeat (ERR_LIMIT) @(negedge clk);
    drop_a[1] = 1'b0;
    check("mon_trip_done1", ifa.O_lane_dpa_done[1], 0);
    check("mon_trip_done0", ifa.O_lane_dpa_done[0], 1);
    @(negedge clk);
    check("mon_trip_busy", ifa.O_busy, 1);
    check("mon_trip_all_done", ifa.O_all_done, 0);
    wait_idle_a();
    @(negedge clk);
    check("mon_rescan_idelay0", ifa.O_idelay_num[TAP_W-1:0], idl0_saved);
    check("mon_rescan_done0", ifa.O_lane_dpa_done[0], 1);
    check_lane_a(1, "mon_rescan");
    check("mon_rescan_all_done", ifa.O_all_done, 1);

    // Abort with a start pulse while lane 1 is at tap 30
    pulse_a();
    n = 0;
    while (ifa.O_lane_dpa_done[0] !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    n = 0;
    while (ifa.O_idelay_num[TAP_W +: TAP_W] != 8'd30 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("abort_reach_tap30", ifa.O_idelay_num[TAP_W +: TAP_W], 30);
    ifa.I_dpa_start = 1'b1;
    @(negedge clk);
    ifa.I_dpa_start = 1'b0;
    check("abort_done", ifa.O_lane_dpa_done, 0);
    check("abort_fail", ifa.O_lane_fail, 0);
    check("abort_eye", ifa.O_eye_taps, 0);
    check("abort_busy", ifa.O_busy, 1);
    @(negedge clk);
    check("abort_all_done", ifa.O_all_done, 0);
    check("abort_idelay0", ifa.O_idelay_num[TAP_W-1:0], 0);
    check("abort_idelay1_held", ifa.O_idelay_num[TAP_W +: TAP_W], 30);
    wait_idle_a();
    @(negedge clk);
    check_lane_a(0, "abort_end");
    check_lane_a(1, "abort_end");

    // Asynchronous reset in the middle of a scan
    pulse_a();
    repeat (200) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", ifa.O_busy, 0);
    check("arst_all_done", ifa.O_all_done, 0);
    check("arst_done", ifa.O_lane_dpa_done, 0);
    check("arst_fail", ifa.O_lane_fail, 0);
    check("arst_idelay", ifa.O_idelay_num, 0);
    check("arst_eye", ifa.O_eye_taps, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("arst_idle_busy", ifa.O_busy, 0);
    check("arst_idle_idelay", ifa.O_idelay_num, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
